wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter VLEN, default 4: vector lanes per vector instruction, a power of two from 2 to 16.
REQ-002 SHALL have parameter LW, default $clog2(VLEN): lane index width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port x2_valid, input, 1: execute-2 presents an instruction (or one vector lane) this cycle.
REQ-006 SHALL have port x2_ins, input, 16: instruction; opcode [15:12], ra [11:8], subcode/rb [7:4], rt [3:0].
REQ-007 SHALL have port x2_result, input, 16: ALU/lane result from execute-2.
REQ-008 SHALL have ports x2_ra_val and x2_rt_val, inputs, 16 each: register operand values.
REQ-009 SHALL have port mem_rdata, input, 16: load data for the instruction at x2.
REQ-010 SHALL have ports x2_lane (input, LW: lane index) and x2_last (input, 1: final lane).
REQ-011 SHALL have outputs reg_we (1), reg_waddr (4) and reg_wdata (16): scalar register-file write port.
REQ-012 SHALL have outputs vreg_we (1), vreg_waddr (4), vreg_lane (LW) and vreg_wdata (16): vector register-file write port.
REQ-013 SHALL have outputs flush (1) and flush_pc (16): taken-jump redirect to fetch.
REQ-014 SHALL have outputs halted (1), vbusy (1: vector sequence in progress) and retired (16: retired-instruction count).

Function
REQ-015 SHALL decode these opcodes; all others are no-ops:
- scalar ALU: 0000 add, 0001 sub, 0010 mul, 0011 div
- movl 0100, movh 0101, jmp 0110, ld/st 0111 (subcode 0 = ld, 1 = st)
- vector: 1000-1011 vadd/vsub/vmul/vdiv, 1100 vld, 1101 vst, 1110 vdot
- halt 1111
REQ-016 SHALL register all outputs, so that each output reflects the x2 inputs one cycle after the x2_valid cycle.
REQ-017 SHALL handle scalar ALU ops as: reg_we = 1, reg_waddr = rt, reg_wdata = x2_result.
REQ-018 SHALL handle movl as: reg_wdata = zero-extended ins[11:4].
REQ-019 SHALL handle movh as: reg_wdata = {ins[11:4], x2_rt_val[7:0]}.
REQ-020 SHALL handle ld as: reg_wdata = mem_rdata; st SHALL write no register.
REQ-021 SHALL resolve jmp using rt_val:
- subcode 0 jz: taken if rt_val == 0
- subcode 1 jnz: taken if rt_val != 0
- subcode 2 js: taken if rt_val[15] == 1
- subcode 3 jns: taken if rt_val[15] == 0
- other subcodes: not taken
REQ-022 SHALL, on a taken jump, pulse flush for exactly 1 cycle with flush_pc = x2_ra_val; jumps SHALL write no register.
REQ-023 SHALL never write register 0: reg_we SHALL be forced to 0 when the destination is 0; this does not apply to vreg.
REQ-024 SHALL use a two-state FSM: VIDLE and VSEQ.
REQ-025 SHALL, in VIDLE, treat a valid vector op with x2_lane == 0 as the start of a sequence; if x2_last == 0 the FSM SHALL enter VSEQ and vbusy SHALL = 1.
REQ-026 SHALL, in VSEQ, accept only lanes whose x2_lane equals the expected lane (previous + 1); a mismatch or a non-vector op SHALL abort to VIDLE with no write for that cycle.
REQ-027 SHALL return to VIDLE on an accepted lane with x2_last = 1, or on a lane index of VLEN-1.
REQ-028 SHALL handle vadd/vsub/vmul/vdiv/vld per lane as: vreg_we = 1, vreg_waddr = rt, vreg_lane = x2_lane, vreg_wdata = x2_result (mem_rdata for vld).
REQ-029 SHALL handle vst as a no-write operation that still advances the lane sequence.
REQ-030 SHALL handle vdot by accumulating x2_result into a 16-bit accumulator (wrap-around modulo 2^16), cleared at lane 0, with no per-lane writes.
REQ-031 SHALL, on the final vdot lane, write the scalar register: reg_we = 1, reg_waddr = rt, reg_wdata = acc + final lane.
REQ-032 SHALL count retired as +1 per completed scalar instruction and +1 per completed vector sequence (not per lane); an aborted sequence SHALL not count; the counter SHALL wrap at 0xFFFF → 0.
REQ-033 SHALL, on halt, set halted = 1 and keep it set until rst.
REQ-034 SHALL, while halted, ignore x2_valid: no writes, no flush, no retire.
REQ-035 SHALL treat x2_valid = 0 cycles as a gap: all write-enables and flush SHALL be 0 and FSM state SHALL be held (bubbles inside a vector sequence are legal).

Reset
REQ-036 SHALL, when rst = 1 at a clock edge, clear all of the following: reg_we, vreg_we, flush, halted, vbusy, retired, the accumulator and all address/data outputs, and set the FSM to VIDLE.
REQ-037 SHALL, on reset in the middle of a vector sequence, discard the sequence with no further writes; rst SHALL take priority over x2_valid in the same cycle.

Verification
REQ-038 SHALL cover: add with rt = 3, result 0x1234 → next cycle reg_we = 1, reg_waddr = 3, reg_wdata = 0x1234; retired = 1.
REQ-039 SHALL cover: jz with rt_val = 0 and ra_val = 0x0040 → flush high for 1 cycle, flush_pc = 0x0040; the same op with rt_val = 5 → no flush.
REQ-040 SHALL cover: vadd rt = 2 over lanes 0-3 with results 1, 2, 3, 4 and one bubble between lanes 1 and 2 → four vreg writes at lanes 0-3; vbusy high from lane 0 through lane 2; retired += 1.
REQ-041 SHALL cover: vdot rt = 5 with lanes 0xFFFF, 2, 3, 4 → a single reg write 0x0008 (wrapped) at reg 5, and no vreg writes.
REQ-042 SHALL cover: vector lanes 0 then 2 (skipping lane 1) → abort, no write for lane 2, FSM in VIDLE, retired unchanged.
REQ-043 SHALL cover: halt, then an add → halted = 1 and no add write; then rst for 1 cycle mid-vector sequence → all outputs 0, vbusy = 0, halted = 0.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: retires scalar ops, sequences vector lanes, resolves jumps.
// Ports: x2_* execute-2 inputs; reg_*/vreg_* write ports; flush/flush_pc
// redirect; halted, vbusy and retired status.
module wb_stage #(
  parameter int VLEN = 4,
  parameter int LW   = $clog2(VLEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          x2_valid,
  input  logic [15:0]   x2_ins,
  input  logic [15:0]   x2_result,
  input  logic [15:0]   x2_ra_val,
  input  logic [15:0]   x2_rt_val,
  input  logic [15:0]   mem_rdata,
  input  logic [LW-1:0] x2_lane,
  input  logic          x2_last,
  output logic          reg_we,
  output logic [3:0]    reg_waddr,
  output logic [15:0]   reg_wdata,
  output logic          vreg_we,
  output logic [3:0]    vreg_waddr,
  output logic [LW-1:0] vreg_lane,
  output logic [15:0]   vreg_wdata,
  output logic          flush,
  output logic [15:0]   flush_pc,
  output logic          halted,
  output logic          vbusy,
  output logic [15:0]   retired
);

  localparam logic [0:0] VIDLE = 1'b0;
  localparam logic [0:0] VSEQ  = 1'b1;
  localparam logic [LW-1:0] LAST_LANE = LW'(VLEN - 1);

  logic [0:0]    state;
  logic [0:0]    state_n;
  logic [LW-1:0] exp_lane;
  logic [LW-1:0] exp_lane_n;
  logic [15:0]   acc;
  logic [15:0]   acc_n;
  logic [3:0]    op;
  logic [3:0]    sub;
  logic [3:0]    rt;
  logic          is_vec;
  logic          live;
  logic          lane_ok;
  logic          accept;
  logic          done;
  logic          taken;
  logic [15:0]   sum;
  logic          reg_wr;
  logic [15:0]   reg_val;
  logic          vreg_wr;
  logic [15:0]   vreg_val;
  logic          flush_n;
  logic          halted_n;
  logic          retire;

  always_comb begin
    op     = x2_ins[15:12];
    sub    = x2_ins[7:4];
    rt     = x2_ins[3:0];
    is_vec = op[3] && (op != 4'hF);
    live   = x2_valid && !halted;
    lane_ok = (state == VSEQ) ? (x2_lane == exp_lane)
                              : (x2_lane == '0);
    accept = live && is_vec && lane_ok;
    done   = x2_last || (x2_lane == LAST_LANE);
    // lane 0 starts a fresh dot product
    sum    = ((state == VSEQ) ? acc : 16'h0) + x2_result;

    case (sub)
      4'd0:    taken = (x2_rt_val == 16'h0);
      4'd1:    taken = (x2_rt_val != 16'h0);
      4'd2:    taken = x2_rt_val[15];
      4'd3:    taken = !x2_rt_val[15];
      default: taken = 1'b0;
    endcase

    state_n    = state;
    exp_lane_n = exp_lane;
    acc_n      = acc;
    reg_wr     = 1'b0;
    reg_val    = x2_result;
    vreg_wr    = 1'b0;
    vreg_val   = x2_result;
    flush_n    = 1'b0;
    halted_n   = halted;
    retire     = 1'b0;

    if (live && state == VIDLE && !is_vec) begin
      case (op)
        4'h0, 4'h1, 4'h2, 4'h3: begin
          reg_wr = 1'b1;
          retire = 1'b1;
        end
        4'h4: begin
          reg_wr  = 1'b1;
          reg_val = {8'h00, x2_ins[11:4]};
          retire  = 1'b1;
        end
        4'h5: begin
          reg_wr  = 1'b1;
          reg_val = {x2_ins[11:4], x2_rt_val[7:0]};
          retire  = 1'b1;
        end
        4'h6: begin
          flush_n = taken;
          retire  = 1'b1;
        end
        4'h7: begin
          if (sub == 4'd0) begin
            reg_wr  = 1'b1;
            reg_val = mem_rdata;
            retire  = 1'b1;
          end else if (sub == 4'd1) begin
            retire = 1'b1;
          end
        end
        4'hF: begin
          halted_n = 1'b1;
          retire   = 1'b1;
        end
        default: ;
      endcase
    end else if (accept) begin
      acc_n = sum;
      case (op)
        4'h8, 4'h9, 4'hA, 4'hB: vreg_wr = 1'b1;
        4'hC: begin
          vreg_wr  = 1'b1;
          vreg_val = mem_rdata;
        end
        4'hE: begin
          reg_wr  = done;
          reg_val = sum;
        end
        default: ;
      endcase
      if (done) begin
        state_n = VIDLE;
        retire  = 1'b1;
      end else begin
        state_n    = VSEQ;
        exp_lane_n = x2_lane + 1'b1;
      end
    end else if (live && state == VSEQ) begin
      // out-of-order lane or foreign op kills the sequence
      state_n = VIDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= VIDLE;
      exp_lane   <= '0;
      acc        <= 16'h0;
      reg_we     <= 1'b0;
      reg_waddr  <= 4'h0;
      reg_wdata  <= 16'h0;
      vreg_we    <= 1'b0;
      vreg_waddr <= 4'h0;
      vreg_lane  <= '0;
      vreg_wdata <= 16'h0;
      flush      <= 1'b0;
      flush_pc   <= 16'h0;
      halted     <= 1'b0;
      vbusy      <= 1'b0;
      retired    <= 16'h0;
    end else begin
      state    <= state_n;
      exp_lane <= exp_lane_n;
      acc      <= acc_n;
      halted   <= halted_n;
      vbusy    <= (state_n == VSEQ);
      retired  <= retired + {15'd0, retire};
      reg_we   <= reg_wr && (rt != 4'h0);
      if (reg_wr && rt != 4'h0) begin
        reg_waddr <= rt;
        reg_wdata <= reg_val;
      end
      vreg_we <= vreg_wr;
      if (vreg_wr) begin
        vreg_waddr <= rt;
        vreg_lane  <= x2_lane;
        vreg_wdata <= vreg_val;
      end
      flush <= flush_n;
      if (flush_n) flush_pc <= x2_ra_val;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: vector table, corner sequences, random vs model.
// Model tracks sequence/halt/retire state in plain procedural terms.
module tb_wb_stage;
  localparam int VLEN = 4;
  localparam int LW   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          x2_valid;
  logic [15:0]   x2_ins;
  logic [15:0]   x2_result;
  logic [15:0]   x2_ra_val;
  logic [15:0]   x2_rt_val;
  logic [15:0]   mem_rdata;
  logic [LW-1:0] x2_lane;
  logic          x2_last;
  logic          reg_we;
  logic [3:0]    reg_waddr;
  logic [15:0]   reg_wdata;
  logic          vreg_we;
  logic [3:0]    vreg_waddr;
  logic [LW-1:0] vreg_lane;
  logic [15:0]   vreg_wdata;
  logic          flush;
  logic [15:0]   flush_pc;
  logic          halted;
  logic          vbusy;
  logic [15:0]   retired;

  always #5 clk = ~clk;

  wb_stage #(.VLEN(VLEN), .LW(LW)) dut (
    .clk(clk), .rst(rst), .x2_valid(x2_valid),
    .x2_ins(x2_ins), .x2_result(x2_result),
    .x2_ra_val(x2_ra_val), .x2_rt_val(x2_rt_val),
    .mem_rdata(mem_rdata), .x2_lane(x2_lane),
    .x2_last(x2_last), .reg_we(reg_we),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .vreg_we(vreg_we), .vreg_waddr(vreg_waddr),
    .vreg_lane(vreg_lane), .vreg_wdata(vreg_wdata),
    .flush(flush), .flush_pc(flush_pc),
    .halted(halted), .vbusy(vbusy), .retired(retired)
  );

  int    errors = 0;
  int    checks = 0;
  string tag = "init";

  // reference model state
  bit          m_halted;
  bit          m_inseq;
  int          m_next;
  logic [15:0] m_acc;
  logic [15:0] m_retired;
  logic        e_we;
  logic [3:0]  e_wa;
  logic [15:0] e_wd;
  logic        e_vwe;
  logic [3:0]  e_vwa;
  logic [1:0]  e_vl;
  logic [15:0] e_vwd;
  logic        e_fl;
  logic [15:0] e_pc;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] res;
    logic [15:0] ra;
    logic [15:0] rtv;
    logic [15:0] mem;
    logic        v;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        fl;
    logic [15:0] pc;
  } row_t;

  row_t tbl[14];

  function automatic row_t mk(
    input logic v, input logic [15:0] ins, res, ra, rtv, mem,
    input logic we, input logic [3:0] wa, input logic [15:0] wd,
    input logic fl, input logic [15:0] pc);
    row_t r;
    r.v = v; r.ins = ins; r.res = res; r.ra = ra;
    r.rtv = rtv; r.mem = mem; r.we = we; r.wa = wa;
    r.wd = wd; r.fl = fl; r.pc = pc;
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [15:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %h want %h", tag, name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_halted = 0; m_inseq = 0; m_next = 0;
    m_acc = '0; m_retired = '0;
    e_we = 0; e_vwe = 0; e_fl = 0;
  endtask

  task automatic wr(input logic [3:0] rt, input logic [15:0] val);
    e_we = (rt != 0); e_wa = rt; e_wd = val;
    m_retired = m_retired + 16'd1;
  endtask

  task automatic model_step(
    input logic v, input logic [15:0] ins, res, ra, rtv, mem,
    input logic [1:0] lane, input logic last);
    int op;
    int sub;
    logic [3:0] rt;
    bit vec;
    bit fin;
    e_we = 0; e_vwe = 0; e_fl = 0;
    if (!v || m_halted) return;
    op  = int'(ins[15:12]);
    sub = int'(ins[7:4]);
    rt  = ins[3:0];
    vec = (op >= 8 && op <= 14);
    if (m_inseq && (!vec || int'(lane) != m_next)) begin
      m_inseq = 0;
      return;
    end
    if (vec) begin
      if (!m_inseq && lane != 0) return;
      if (!m_inseq) m_acc = '0;
      m_acc = m_acc + res;
      fin = last || (int'(lane) == VLEN - 1);
      if (op <= 12) begin
        e_vwe = 1; e_vwa = rt; e_vl = lane;
        e_vwd = (op == 12) ? mem : res;
      end
      if (op == 14 && fin) begin
        e_we = (rt != 0); e_wa = rt; e_wd = m_acc;
      end
      if (fin) begin
        m_inseq = 0;
        m_retired = m_retired + 16'd1;
      end else begin
        m_inseq = 1;
        m_next = int'(lane) + 1;
      end
      return;
    end
    case (op)
      0, 1, 2, 3: wr(rt, res);
      4: wr(rt, {8'h00, ins[11:4]});
      5: wr(rt, {ins[11:4], rtv[7:0]});
      6: begin
        m_retired = m_retired + 16'd1;
        e_pc = ra;
        e_fl = (sub == 0 && rtv == 0) || (sub == 1 && rtv != 0) ||
               (sub == 2 && rtv[15]) || (sub == 3 && !rtv[15]);
      end
      7: begin
        if (sub == 0) wr(rt, mem);
        else if (sub == 1) m_retired = m_retired + 16'd1;
      end
      15: begin
        m_halted = 1;
        m_retired = m_retired + 16'd1;
      end
      default: ;
    endcase
  endtask

  task automatic compare_model();
    chk("reg_we", {15'd0, reg_we}, {15'd0, e_we});
    if (e_we) begin
      chk("reg_waddr", {12'd0, reg_waddr}, {12'd0, e_wa});
      chk("reg_wdata", reg_wdata, e_wd);
    end
    chk("vreg_we", {15'd0, vreg_we}, {15'd0, e_vwe});
    if (e_vwe) begin
      chk("vreg_waddr", {12'd0, vreg_waddr}, {12'd0, e_vwa});
      chk("vreg_lane", {14'd0, vreg_lane}, {14'd0, e_vl});
      chk("vreg_wdata", vreg_wdata, e_vwd);
    end
    chk("flush", {15'd0, flush}, {15'd0, e_fl});
    if (e_fl) chk("flush_pc", flush_pc, e_pc);
    chk("halted", {15'd0, halted}, {15'd0, m_halted});
    chk("vbusy", {15'd0, vbusy}, {15'd0, m_inseq});
    chk("retired", retired, m_retired);
  endtask

  task automatic step(
    input logic v, input logic [15:0] ins, res, ra, rtv, mem,
    input logic [1:0] lane, input logic last);
    x2_valid = v; x2_ins = ins; x2_result = res;
    x2_ra_val = ra; x2_rt_val = rtv; mem_rdata = mem;
    x2_lane = lane; x2_last = last;
    model_step(v, ins, res, ra, rtv, mem, lane, last);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_reg_we", {15'd0, reg_we}, 16'd0);
    chk("rst_reg_waddr", {12'd0, reg_waddr}, 16'd0);
    chk("rst_reg_wdata", reg_wdata, 16'd0);
    chk("rst_vreg_we", {15'd0, vreg_we}, 16'd0);
    chk("rst_vreg_waddr", {12'd0, vreg_waddr}, 16'd0);
    chk("rst_vreg_lane", {14'd0, vreg_lane}, 16'd0);
    chk("rst_vreg_wdata", vreg_wdata, 16'd0);
    chk("rst_flush", {15'd0, flush}, 16'd0);
    chk("rst_flush_pc", flush_pc, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_vbusy", {15'd0, vbusy}, 16'd0);
    chk("rst_retired", retired, 16'd0);
  endtask

  function automatic logic [15:0] r16();
    return 16'($urandom);
  endfunction

  function automatic logic [15:0] rnd_scalar(input bit allow_halt);
    logic [3:0] op;
    logic [3:0] sub;
    if (allow_halt && $urandom_range(0, 99) < 2) return 16'hF000;
    op = 4'($urandom_range(0, 7));
    sub = 4'($urandom_range(0, 15));
    if (op == 4'h7) sub = 4'($urandom_range(0, 1));
    if (op == 4'h6) sub = 4'($urandom_range(0, 5));
    return {op, 4'($urandom_range(0, 15)), sub,
            4'($urandom_range(0, 15))};
  endfunction

  function automatic logic [15:0] rnd_rtv();
    int k;
    k = $urandom_range(0, 2);
    if (k == 0) return 16'h0000;
    if (k == 1) return r16() | 16'h8000;
    return r16() & 16'h7FFF;
  endfunction

  initial begin
    logic [15:0] vins;
    int n;
    int c;
    logic lst;
    rst = 1'b1;
    x2_valid = 0; x2_ins = '0; x2_result = '0;
    x2_ra_val = '0; x2_rt_val = '0; mem_rdata = '0;
    x2_lane = '0; x2_last = 0;
    tag = "reset";
    do_reset();

    tbl[0]  = mk(1, 16'h0003, 16'h1234, 0, 0, 0, 1, 3, 16'h1234, 0, 0);
    tbl[1]  = mk(1, 16'h1007, 16'hBEEF, 0, 0, 0, 1, 7, 16'hBEEF, 0, 0);
    tbl[2]  = mk(1, 16'h2000, 16'h5555, 0, 0, 0, 0, 0, 16'h0000, 0, 0);
    tbl[3]  = mk(1, 16'h4AB1, 16'h7777, 0, 0, 0, 1, 1, 16'h00AB, 0, 0);
    tbl[4]  = mk(1, 16'h5CD2, 0, 0, 16'h1234, 0, 1, 2, 16'hCD34, 0, 0);
    tbl[5]  = mk(1, 16'h7004, 0, 0, 0, 16'h0F0F, 1, 4, 16'h0F0F, 0, 0);
    tbl[6]  = mk(1, 16'h7014, 0, 0, 0, 16'h1111, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 16'h6005, 0, 16'h0040, 16'h0000, 0,
                 0, 0, 0, 1, 16'h0040);
    tbl[8]  = mk(1, 16'h6005, 0, 16'h0040, 16'h0005, 0,
                 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 16'h6015, 0, 16'h0100, 16'h0005, 0,
                 0, 0, 0, 1, 16'h0100);
    tbl[10] = mk(1, 16'h6025, 0, 16'h0200, 16'h8000, 0,
                 0, 0, 0, 1, 16'h0200);
    tbl[11] = mk(1, 16'h6035, 0, 16'h0300, 16'h8000, 0,
                 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 16'h6045, 0, 16'h0400, 16'h0000, 0,
                 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 16'h0003, 16'h4321, 0, 0, 0, 0, 0, 0, 0, 0);

    tag = "table";
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].v, tbl[i].ins, tbl[i].res, tbl[i].ra,
           tbl[i].rtv, tbl[i].mem, 2'd0, 1'b0);
      chk("t_we", {15'd0, reg_we}, {15'd0, tbl[i].we});
      if (tbl[i].we) begin
        chk("t_waddr", {12'd0, reg_waddr}, {12'd0, tbl[i].wa});
        chk("t_wdata", reg_wdata, tbl[i].wd);
      end
      chk("t_flush", {15'd0, flush}, {15'd0, tbl[i].fl});
      if (tbl[i].fl) chk("t_pc", flush_pc, tbl[i].pc);
    end
    chk("t_retired", retired, 16'd13);

    tag = "vadd";
    step(1, 16'h8002, 16'd1, 0, 0, 0, 2'd0, 0);
    chk("l0_we", {15'd0, vreg_we}, 16'd1);
    chk("l0_addr", {12'd0, vreg_waddr}, 16'd2);
    chk("l0_data", vreg_wdata, 16'd1);
    chk("l0_busy", {15'd0, vbusy}, 16'd1);
    step(1, 16'h8002, 16'd2, 0, 0, 0, 2'd1, 0);
    chk("l1_lane", {14'd0, vreg_lane}, 16'd1);
    chk("l1_data", vreg_wdata, 16'd2);
    step(0, 16'h8002, 16'd9, 0, 0, 0, 2'd2, 0);
    chk("gap_we", {15'd0, vreg_we}, 16'd0);
    chk("gap_busy", {15'd0, vbusy}, 16'd1);
    step(1, 16'h8002, 16'd3, 0, 0, 0, 2'd2, 0);
    chk("l2_data", vreg_wdata, 16'd3);
    chk("l2_busy", {15'd0, vbusy}, 16'd1);
    step(1, 16'h8002, 16'd4, 0, 0, 0, 2'd3, 1);
    chk("l3_lane", {14'd0, vreg_lane}, 16'd3);
    chk("l3_data", vreg_wdata, 16'd4);
    chk("l3_busy", {15'd0, vbusy}, 16'd0);
    chk("retired", retired, 16'd14);

    tag = "vdot";
    step(1, 16'hE005, 16'hFFFF, 0, 0, 0, 2'd0, 0);
    chk("d0_vwe", {15'd0, vreg_we}, 16'd0);
    step(1, 16'hE005, 16'd2, 0, 0, 0, 2'd1, 0);
    step(1, 16'hE005, 16'd3, 0, 0, 0, 2'd2, 0);
    chk("d2_we", {15'd0, reg_we}, 16'd0);
    step(1, 16'hE005, 16'd4, 0, 0, 0, 2'd3, 1);
    chk("d3_we", {15'd0, reg_we}, 16'd1);
    chk("d3_addr", {12'd0, reg_waddr}, 16'd5);
    chk("d3_data", reg_wdata, 16'h0008);
    chk("d3_vwe", {15'd0, vreg_we}, 16'd0);
    chk("retired", retired, 16'd15);

    tag = "abort";
    step(1, 16'h8002, 16'd9, 0, 0, 0, 2'd0, 0);
    chk("a0_busy", {15'd0, vbusy}, 16'd1);
    step(1, 16'h8002, 16'd7, 0, 0, 0, 2'd2, 0);
    chk("a2_vwe", {15'd0, vreg_we}, 16'd0);
    chk("a2_busy", {15'd0, vbusy}, 16'd0);
    chk("retired", retired, 16'd15);

    tag = "halt";
    step(1, 16'hF000, 0, 0, 0, 0, 2'd0, 0);
    chk("h_halted", {15'd0, halted}, 16'd1);
    chk("h_retired", retired, 16'd16);
    step(1, 16'h0003, 16'h9999, 0, 0, 0, 2'd0, 0);
    chk("h_add_we", {15'd0, reg_we}, 16'd0);
    chk("h_held", {15'd0, halted}, 16'd1);
    chk("h_ret2", retired, 16'd16);
    do_reset();
    step(1, 16'h8002, 16'd1, 0, 0, 0, 2'd0, 0);
    step(1, 16'h8002, 16'd2, 0, 0, 0, 2'd1, 0);
    tag = "midrst";
    x2_valid = 1; x2_ins = 16'h8002; x2_result = 16'd3;
    x2_lane = 2'd2; x2_last = 0;
    do_reset();
    step(1, 16'h8002, 16'd4, 0, 0, 0, 2'd3, 1);
    chk("after_vwe", {15'd0, vreg_we}, 16'd0);
    chk("after_ret", retired, 16'd0);

    tag = "random";
    for (int it = 0; it < 800; it++) begin
      if (m_halted && $urandom_range(0, 2) == 0) do_reset();
      c = $urandom_range(0, 9);
      if (c <= 4) begin
        step(1, rnd_scalar(1), r16(), r16(), rnd_rtv(), r16(),
             2'd0, 0);
      end else if (c <= 8) begin
        vins = {4'($urandom_range(8, 14)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
        n = $urandom_range(1, VLEN);
        for (int l = 0; l < n; l++) begin
          if ($urandom_range(0, 3) == 0)
            step(0, vins, r16(), r16(), r16(), r16(), 2'(l), 0);
          c = $urandom_range(0, 19);
          if (c == 0) begin
            step(1, vins, r16(), r16(), r16(), r16(), 2'(l + 1), 0);
            break;
          end
          if (c == 1) begin
            step(1, rnd_scalar(0), r16(), r16(), rnd_rtv(), r16(),
                 2'(l), 0);
            break;
          end
          lst = (l == n - 1) ?
                ((n == VLEN) ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
          step(1, vins, r16(), r16(), r16(), r16(), 2'(l), lst);
        end
      end else begin
        step(0, rnd_scalar(1), r16(), r16(), r16(), r16(), 2'd0, 0);
      end
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
